systolic_feed_scheduler: RTL

//  Sequencer for the output-stationary systolic_array_top datapath. On start, it captures the flattened A and B operand matrices.
//  It then injects A rows on the left edge and B columns on the top edge with the diagonal skew the array needs.
//  It times the drain of the wavefront and reports completion with a done/result_valid handshake.
//  It sits between the host/command logic and the PE grid and owns the computing, input_cycle and accumulator-clear controls.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_feed_scheduler_skew.sv | 39 +++
 rtl/systolic_feed_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic feed scheduler and the array it drives.
package systolic_pkg;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_e;

  function automatic int unsigned feed_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

  function automatic int unsigned drain_cycles(input int unsigned n, input int unsigned l);
    return n - 1 + l;
  endfunction

  // Row-major element index into a flattened N x N matrix.
  function automatic int unsigned flat_idx(input int unsigned row, input int unsigned col,
                                           input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/systolic_feed_scheduler_skew.sv
// Skewed edge selector: for step t, edge lane e carries element k = t - e when 0 <= k < N.
module skew_select
  import systolic_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 16,
  parameter int unsigned TW        = 3,
  parameter bit          TRANSPOSE = 1'b0
) (
  input  logic [TW-1:0]      i_t,
  input  logic [W*N*N-1:0]   i_matrix,
  output logic [W*N-1:0]     o_data,
  output logic [N-1:0]       o_valid
);

  logic [31:0] w_t;
  logic [31:0] w_k;
  logic [31:0] w_idx;

  assign w_t = 32'(i_t);

  always_comb begin
    o_data  = '0;
    o_valid = '0;
    w_k     = '0;
    w_idx   = '0;
    for (int unsigned e = 0; e < N; e++) begin
      w_k   = w_t - e;
      w_idx = '0;
      if (w_t >= e && w_k < N) begin
        // Columns walk down B's rows, so the lane selects the column instead of the row.
        w_idx              = TRANSPOSE ? flat_idx(w_k, e, N) : flat_idx(e, w_k, N);
        o_data[e*W +: W]   = i_matrix[w_idx*W +: W];
        o_valid[e]         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Sequencer for an output-stationary systolic array: latches A/B, feeds skewed edges,
// times the drain and signals completion.
module systolic_feed_scheduler
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE   = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned PE_LATENCY   = 1
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic                                           i_start,
  input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]    i_matrix_a_flat,
  input  logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]  i_matrix_b_flat,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0]               o_data_h,
  output logic [ARRAY_SIZE-1:0]                          o_data_h_valid,
  output logic [WEIGHT_WIDTH*ARRAY_SIZE-1:0]             o_weight_v,
  output logic [ARRAY_SIZE-1:0]                          o_weight_v_valid,
  output logic                                           o_acc_clear,
  output logic                                           o_computing,
  output logic [$clog2(2*ARRAY_SIZE)-1:0]                o_input_cycle,
  output logic                                           o_busy,
  output logic                                           o_done,
  output logic                                           o_result_valid
);

  localparam int unsigned N     = ARRAY_SIZE;
  localparam int unsigned FEED  = feed_cycles(N);
  localparam int unsigned DRAIN = drain_cycles(N, PE_LATENCY);
  localparam int unsigned TW    = $clog2(2 * N);
  localparam int unsigned DCW   = $clog2(DRAIN + 1);

  state_e                              r_state;
  logic [TW-1:0]                       r_t;
  logic [DCW-1:0]                      r_drain;
  logic [DATA_WIDTH*N*N-1:0]           r_mat_a;
  logic [WEIGHT_WIDTH*N*N-1:0]         r_mat_b;
  logic [DATA_WIDTH*N-1:0]             r_data_h;
  logic [N-1:0]                        r_data_h_valid;
  logic [WEIGHT_WIDTH*N-1:0]           r_weight_v;
  logic [N-1:0]                        r_weight_v_valid;
  logic                                r_acc_clear;
  logic                                r_computing;
  logic                                r_busy;
  logic                                r_done;
  logic                                r_result_valid;

  logic [DATA_WIDTH*N-1:0]             w_data_h;
  logic [N-1:0]                        w_data_h_valid;
  logic [WEIGHT_WIDTH*N-1:0]           w_weight_v;
  logic [N-1:0]                        w_weight_v_valid;

  skew_select #(
    .N         (N),
    .W         (DATA_WIDTH),
    .TW        (TW),
    .TRANSPOSE (1'b0)
  ) u_skew_rows (
    .i_t      (r_t),
    .i_matrix (r_mat_a),
    .o_data   (w_data_h),
    .o_valid  (w_data_h_valid)
  );

  skew_select #(
    .N         (N),
    .W         (WEIGHT_WIDTH),
    .TW        (TW),
    .TRANSPOSE (1'b1)
  ) u_skew_cols (
    .i_t      (r_t),
    .i_matrix (r_mat_b),
    .o_data   (w_weight_v),
    .o_valid  (w_weight_v_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_t              <= '0;
      r_drain          <= '0;
      r_mat_a          <= '0;
      r_mat_b          <= '0;
      r_data_h         <= '0;
      r_data_h_valid   <= '0;
      r_weight_v       <= '0;
      r_weight_v_valid <= '0;
      r_acc_clear      <= 1'b0;
      r_computing      <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_result_valid   <= 1'b0;
    end else begin
      r_acc_clear <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mat_a        <= i_matrix_a_flat;
            r_mat_b        <= i_matrix_b_flat;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b1;
            r_acc_clear    <= 1'b1;
            r_state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_t         <= '0;
          r_computing <= 1'b1;
          r_state     <= S_FEED;
        end
        S_FEED: begin
          // Edge registers trail the t counter by one cycle.
          r_data_h         <= w_data_h;
          r_data_h_valid   <= w_data_h_valid;
          r_weight_v       <= w_weight_v;
          r_weight_v_valid <= w_weight_v_valid;
          if (r_t == TW'(FEED - 1)) begin
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        S_DRAIN: begin
          r_data_h         <= '0;
          r_data_h_valid   <= '0;
          r_weight_v       <= '0;
          r_weight_v_valid <= '0;
          if (r_drain == DCW'(DRAIN - 1)) begin
            r_computing    <= 1'b0;
            r_done         <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_h         = r_data_h;
  assign o_data_h_valid   = r_data_h_valid;
  assign o_weight_v       = r_weight_v;
  assign o_weight_v_valid = r_weight_v_valid;
  assign o_acc_clear      = r_acc_clear;
  assign o_computing      = r_computing;
  assign o_input_cycle    = r_t;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_result_valid   = r_result_valid;

endmodule
